// File: rtl/pk_hasti.sv
// Shared HASTI (AHB-Lite) definitions: transfer/size encodings, response
// values and the size/address to byte-lane-enable mapping.
package pk_hasti;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Byte lanes touched by a transfer on a 32-bit little-endian bus.
  // Misaligned halfwords/words fall back to their natural lanes.
  function automatic logic [3:0] hsize_to_be(input hsize_t hsize, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (hsize)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/if_hasti_slave_io.sv
// HASTI slave-side bus bundle. Modport n is the slave view fed by the
// slave multiplexer.
interface if_hasti_slave_io;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hsel;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  modport n (
    input  haddr, hwrite, hsize, htrans, hwdata, hsel, hready,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/hasti_sram_slave.sv
// HASTI slave in front of a single-port synchronous SRAM, zero wait states.
// Reads strobe the SRAM in the address phase; writes go through a one-entry
// buffer that is committed whenever the SRAM port is not taken by a read.
// Optional build macro HASTI_SRAM_ERR_EN enables out-of-range and
// misalignment error responses (two-cycle ERROR).
module hasti_sram_slave
  import pk_hasti::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic              hclk,
  input  logic              hresetn,
  if_hasti_slave_io.n       in,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    ERR1  = 3'd3,
    ERR2  = 3'd4
  } state_t;

  state_t            state_r;
  logic              hreadyout_r;
  logic              hresp_r;

  logic              accept_s;
  logic              err_s;
  logic              rd_acc_s;
  logic              wr_acc_s;
  logic [MEM_AW-1:0] word_addr_s;
  logic [3:0]        be_s;

  logic              wb_valid_r;
  logic [MEM_AW-1:0] wb_addr_r;
  logic [3:0]        wb_be_r;
  logic [31:0]       wb_data_r;
  logic [MEM_AW-1:0] rd_addr_r;

  logic              commit_s;
  logic [31:0]       commit_data_s;
  logic              wb_hit_s;
  logic [31:0]       rdata_merged_s;

  assign accept_s    = in.hsel && in.hready &&
                       ((in.htrans == HTRANS_NONSEQ) || (in.htrans == HTRANS_SEQ));
  assign word_addr_s = in.haddr[MEM_AW+1:2];
  assign be_s        = hsize_to_be(hsize_t'(in.hsize), in.haddr[1:0]);

`ifdef HASTI_SRAM_ERR_EN
  logic range_err_s;
  logic align_err_s;
  assign range_err_s = (in.haddr >> (MEM_AW + 2)) != 32'd0;
  assign align_err_s = ((in.hsize == HSIZE_HALF) && in.haddr[0]) ||
                       ((in.hsize == HSIZE_WORD) && (in.haddr[1:0] != 2'd0));
  assign err_s       = accept_s && (range_err_s || align_err_s);
`else
  // Upper address bits are ignored so the memory aliases across the space.
  logic unused_haddr_s;
  assign unused_haddr_s = ^in.haddr[31:MEM_AW+2];
  assign err_s          = 1'b0;
`endif

  assign rd_acc_s = accept_s && !in.hwrite && !err_s;
  assign wr_acc_s = accept_s &&  in.hwrite && !err_s;

  // A read owns the SRAM port; the buffered write only goes when it is free.
  // While the buffered write is still in its own data phase its data is live
  // on hwdata rather than in wb_data_r.
  assign commit_s      = wb_valid_r && !rd_acc_s;
  assign commit_data_s = (state_r == WRITE) ? in.hwdata : wb_data_r;
  assign wb_hit_s      = wb_valid_r && (wb_addr_r == rd_addr_r);

  // SRAM request: read strobe in the address phase, else buffered-write commit.
  always_comb begin
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    if (!hresetn) begin
      mem_ce = 1'b0;
    end else if (rd_acc_s) begin
      mem_ce   = 1'b1;
      mem_be   = be_s;
      mem_addr = word_addr_s;
    end else if (commit_s) begin
      mem_ce    = 1'b1;
      mem_we    = 1'b1;
      mem_be    = wb_be_r;
      mem_addr  = wb_addr_r;
      mem_wdata = commit_data_s;
    end else begin
      mem_ce = 1'b0;
    end
  end

  // Read data: pending buffered bytes for the same word override SRAM lanes.
  always_comb begin
    rdata_merged_s = mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (wb_hit_s && wb_be_r[i]) begin
        rdata_merged_s[8*i +: 8] = wb_data_r[8*i +: 8];
      end else begin
        rdata_merged_s[8*i +: 8] = mem_rdata[8*i +: 8];
      end
    end
  end

  assign in.hrdata    = (state_r == READ) ? rdata_merged_s : 32'd0;
  assign in.hreadyout = hreadyout_r;
  assign in.hresp     = hresp_r;

  // Data-phase FSM with registered hreadyout/hresp.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_r     <= IDLE;
      hreadyout_r <= 1'b1;
      hresp_r     <= HRESP_OKAY;
    end else begin
      case (state_r)
        ERR1: begin
          state_r     <= ERR2;
          hreadyout_r <= 1'b1;
          hresp_r     <= HRESP_ERROR;
        end
        IDLE, READ, WRITE, ERR2: begin
          if (err_s) begin
            state_r     <= ERR1;
            hreadyout_r <= 1'b0;
            hresp_r     <= HRESP_ERROR;
          end else if (rd_acc_s) begin
            state_r     <= READ;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
          end else if (wr_acc_s) begin
            state_r     <= WRITE;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
          end else begin
            state_r     <= IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
          end
        end
        default: begin
          state_r     <= IDLE;
          hreadyout_r <= 1'b1;
          hresp_r     <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Read address held for the data-phase merge comparison.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rd_addr_r <= '0;
    end else if (rd_acc_s) begin
      rd_addr_r <= word_addr_s;
    end else begin
      rd_addr_r <= rd_addr_r;
    end
  end

  // Write buffer: address/lanes taken at acceptance, data at the data phase.
  // An accepted write always coincides with a commit of the previous entry.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wb_valid_r <= 1'b0;
      wb_addr_r  <= '0;
      wb_be_r    <= 4'b0000;
      wb_data_r  <= 32'd0;
    end else begin
      if (wr_acc_s) begin
        wb_valid_r <= 1'b1;
        wb_addr_r  <= word_addr_s;
        wb_be_r    <= be_s;
      end else if (commit_s) begin
        wb_valid_r <= 1'b0;
      end else begin
        wb_valid_r <= wb_valid_r;
      end
      if (state_r == WRITE) begin
        wb_data_r <= in.hwdata;
      end else begin
        wb_data_r <= wb_data_r;
      end
    end
  end

endmodule

// File: tb/tb_hasti_sram_slave.sv
// Self-checking bench for hasti_sram_slave with a behavioural single-port
// synchronous SRAM (sram_sp). Read expectations go into a scoreboard queue
// as the read is issued and are matched against hrdata seen in the data phase.
module tb_hasti_sram_slave;
  import pk_hasti::*;

  localparam int MEM_AW = 12;

  logic              hclk;
  logic              hresetn;
  logic              mem_ce;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  if_hasti_slave_io bus();

  hasti_sram_slave #(.MEM_AW(MEM_AW)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .in        (bus),
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // sram_sp: single-port synchronous SRAM, byte-maskable writes
  logic [31:0] sram_mem [0:(1<<MEM_AW)-1];
  always @(posedge hclk) begin : sram_sp
    if (mem_ce) begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) sram_mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else begin
        mem_rdata <= sram_mem[mem_addr];
      end
    end
  end

  typedef struct { logic [31:0] d; logic [31:0] m; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] obs_q[$];
  exp_t        e;
  logic [31:0] o;

  int n_vec = 0;
  int n_err = 0;
  int rdy_low = 0;

  logic        dp_read;
  logic [31:0] dp_wdata;
  logic        last_ce, last_we, last_rdy, last_resp;
  logic [31:0] last_hrdata;

  // One bus cycle: new address phase plus hwdata for the previous transfer;
  // outputs sampled mid-cycle, returns 1 time unit after the next rising edge.
  task automatic bus_cycle(input logic [1:0] tr, input logic sel, input logic wr,
                           input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    bus.hsel   = sel;
    bus.htrans = tr;
    bus.hwrite = wr;
    bus.hsize  = sz;
    bus.haddr  = a;
    bus.hwdata = dp_wdata;
    @(negedge hclk);
    if (dp_read) obs_q.push_back(bus.hrdata);
    if (bus.hreadyout !== 1'b1) rdy_low++;
    last_ce     = mem_ce;
    last_we     = mem_we;
    last_rdy    = bus.hreadyout;
    last_resp   = bus.hresp;
    last_hrdata = bus.hrdata;
    @(posedge hclk);
    #1;
    dp_read  = sel && tr[1] && !wr;
    dp_wdata = wd;
  endtask

  task automatic idle_cycle();
    bus_cycle(HTRANS_IDLE, 1'b0, 1'b0, HSIZE_WORD, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({bus.hreadyout, bus.hresp} !== 2'b10) begin
      n_err++; $display("FAIL reset_resp: got rdy/resp %b required 10", {bus.hreadyout, bus.hresp});
    end
    n_vec++;
    if (bus.hrdata !== 32'd0) begin
      n_err++; $display("FAIL reset_hrdata: got %h required 00000000", bus.hrdata);
    end
    n_vec++;
    if ({mem_ce, mem_we, mem_be} !== 6'd0) begin
      n_err++; $display("FAIL reset_mem_ctl: got %b required 000000", {mem_ce, mem_we, mem_be});
    end
    n_vec++;
    if ({mem_addr, mem_wdata} !== {MEM_AW'(0), 32'd0}) begin
      n_err++; $display("FAIL reset_mem_bus: got addr %h wdata %h required 0", mem_addr, mem_wdata);
    end
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
  endtask

  task automatic test_write_commit();
    int rl0 = rdy_low;
    bus_cycle(HTRANS_NONSEQ, 1'b1, 1'b1, HSIZE_WORD, 32'h10, 32'hDEADBEEF);
    n_vec++;
    if (last_ce !== 1'b0) begin
      n_err++; $display("FAIL wr_addr_phase_ce: got %b required 0", last_ce);
    end
    idle_cycle();
    n_vec++;
    if ({last_ce, last_we} !== 2'b11) begin
      n_err++; $display("FAIL wr_commit_strobe: got ce/we %b required 11", {last_ce, last_we});
    end
    n_vec++;
    if (sram_mem[4] !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL wr_sram_word4: got %h required deadbeef", sram_mem[4]);
    end
    idle_cycle();
    n_vec++;
    if (last_ce !== 1'b0) begin
      n_err++; $display("FAIL wr_buffer_cleared: got ce %b required 0", last_ce);
    end
    n_vec++;
    if (rdy_low !== rl0) begin
      n_err++; $display("FAIL wr_zero_wait: got %0d low cycles required %0d", rdy_low, rl0);
    end
  endtask

  task automatic test_busy_idle();
    bus_cycle(HTRANS_BUSY, 1'b1, 1'b0, HSIZE_WORD, 32'h10, 32'd0);
    n_vec++;
    if ({last_ce, last_rdy, last_resp} !== 3'b010) begin
      n_err++; $display("FAIL busy_no_access: got ce/rdy/resp %b required 010", {last_ce, last_rdy, last_resp});
    end
    bus_cycle(HTRANS_NONSEQ, 1'b0, 1'b0, HSIZE_WORD, 32'h10, 32'd0);
    n_vec++;
    if (last_ce !== 1'b0) begin
      n_err++; $display("FAIL unselected_no_access: got ce %b required 0", last_ce);
    end
    idle_cycle();
    n_vec++;
    if (last_hrdata !== 32'd0) begin
      n_err++; $display("FAIL idle_hrdata: got %h required 00000000", last_hrdata);
    end
  endtask

  task automatic test_read_merge();
    bus_cycle(HTRANS_NONSEQ, 1'b1, 1'b1, HSIZE_WORD, 32'h20, 32'h11223344);
    exp_q.push_back('{d: 32'h11223344, m: 32'hFFFFFFFF});
    bus_cycle(HTRANS_NONSEQ, 1'b1, 1'b0, HSIZE_WORD, 32'h20, 32'd0);
    n_vec++;
    if ({last_ce, last_we} !== 2'b10) begin
      n_err++; $display("FAIL merge_read_first: got ce/we %b required 10", {last_ce, last_we});
    end
    idle_cycle();
    n_vec++;
    if ({last_ce, last_we} !== 2'b11) begin
      n_err++; $display("FAIL merge_commit_after: got ce/we %b required 11", {last_ce, last_we});
    end
    n_vec++;
    if (sram_mem[8] !== 32'h11223344) begin
      n_err++; $display("FAIL merge_sram_word8: got %h required 11223344", sram_mem[8]);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL merge_rdata: got nothing required %h", e.d);
      end else begin
        o = obs_q.pop_front();
        if ((o & e.m) !== (e.d & e.m)) begin
          n_err++; $display("FAIL merge_rdata: got %h required %h", o, e.d);
        end
      end
    end
  endtask

  task automatic test_byte_merge();
    bus_cycle(HTRANS_NONSEQ, 1'b1, 1'b1, HSIZE_WORD, 32'h30, 32'hAABBCCDD);
    idle_cycle();
    idle_cycle();
    bus_cycle(HTRANS_NONSEQ, 1'b1, 1'b1, HSIZE_BYTE, 32'h31, 32'h00005500);
    exp_q.push_back('{d: 32'hAABB55DD, m: 32'hFFFFFFFF});
    bus_cycle(HTRANS_NONSEQ, 1'b1, 1'b0, HSIZE_WORD, 32'h30, 32'd0);
    idle_cycle();
    idle_cycle();
    n_vec++;
    if (sram_mem[12] !== 32'hAABB55DD) begin
      n_err++; $display("FAIL byte_sram_word12: got %h required aabb55dd", sram_mem[12]);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL byte_merge_rdata: got nothing required %h", e.d);
      end else begin
        o = obs_q.pop_front();
        if ((o & e.m) !== (e.d & e.m)) begin
          n_err++; $display("FAIL byte_merge_rdata: got %h required %h", o, e.d);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int rl0 = rdy_low;
    bus_cycle(HTRANS_NONSEQ, 1'b1, 1'b1, HSIZE_WORD, 32'h40, 32'h01020304);
    bus_cycle(HTRANS_SEQ,    1'b1, 1'b1, HSIZE_WORD, 32'h44, 32'hA5A55A5A);
    exp_q.push_back('{d: 32'h01020304, m: 32'hFFFFFFFF});
    bus_cycle(HTRANS_NONSEQ, 1'b1, 1'b0, HSIZE_WORD, 32'h40, 32'd0);
    exp_q.push_back('{d: 32'hA5A55A5A, m: 32'hFFFFFFFF});
    bus_cycle(HTRANS_SEQ,    1'b1, 1'b0, HSIZE_WORD, 32'h44, 32'd0);
    idle_cycle();
    idle_cycle();
    n_vec++;
    if ({sram_mem[16], sram_mem[17]} !== {32'h01020304, 32'hA5A55A5A}) begin
      n_err++; $display("FAIL b2b_sram: got %h %h required 01020304 a5a55a5a", sram_mem[16], sram_mem[17]);
    end
    n_vec++;
    if (rdy_low !== rl0) begin
      n_err++; $display("FAIL b2b_zero_wait: got %0d low cycles required %0d", rdy_low, rl0);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL b2b_rdata: got nothing required %h", e.d);
      end else begin
        o = obs_q.pop_front();
        if ((o & e.m) !== (e.d & e.m)) begin
          n_err++; $display("FAIL b2b_rdata: got %h required %h", o, e.d);
        end
      end
    end
  endtask

  task automatic test_misaligned();
    logic       exp_ce;
    logic [1:0] exp_c2;
    logic [1:0] exp_c3;
    bus_cycle(HTRANS_NONSEQ, 1'b1, 1'b1, HSIZE_WORD, 32'h0, 32'hCAFE1234);
    idle_cycle();
    idle_cycle();
`ifdef HASTI_SRAM_ERR_EN
    exp_ce = 1'b0; exp_c2 = 2'b01; exp_c3 = 2'b11;
    exp_q.push_back('{d: 32'h00000000, m: 32'hFFFFFFFF});
`else
    exp_ce = 1'b1; exp_c2 = 2'b10; exp_c3 = 2'b10;
    exp_q.push_back('{d: 32'h00001234, m: 32'h0000FFFF});
`endif
    bus_cycle(HTRANS_NONSEQ, 1'b1, 1'b0, HSIZE_HALF, 32'h1, 32'd0);
    n_vec++;
    if (last_ce !== exp_ce) begin
      n_err++; $display("FAIL misal_ce: got %b required %b", last_ce, exp_ce);
    end
    idle_cycle();
    n_vec++;
    if ({last_rdy, last_resp} !== exp_c2) begin
      n_err++; $display("FAIL misal_first_resp: got rdy/resp %b required %b", {last_rdy, last_resp}, exp_c2);
    end
    idle_cycle();
    n_vec++;
    if ({last_rdy, last_resp} !== exp_c3) begin
      n_err++; $display("FAIL misal_second_resp: got rdy/resp %b required %b", {last_rdy, last_resp}, exp_c3);
    end
    idle_cycle();
    n_vec++;
    if ({last_rdy, last_resp} !== 2'b10) begin
      n_err++; $display("FAIL misal_recovered: got rdy/resp %b required 10", {last_rdy, last_resp});
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL misal_rdata: got nothing required %h", e.d);
      end else begin
        o = obs_q.pop_front();
        if ((o & e.m) !== (e.d & e.m)) begin
          n_err++; $display("FAIL misal_rdata: got %h required %h", o & e.m, e.d);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bus_cycle(HTRANS_NONSEQ, 1'b1, 1'b1, HSIZE_WORD, 32'h60, 32'h0BADF00D);
    idle_cycle();
    idle_cycle();
    bus_cycle(HTRANS_NONSEQ, 1'b1, 1'b1, HSIZE_WORD, 32'h60, 32'h12345678);
    bus.hsel   = 1'b0;
    bus.htrans = HTRANS_IDLE;
    bus.hwdata = 32'h12345678;
    #2;
    hresetn = 1'b0;
    #1;
    n_vec++;
    if ({mem_ce, mem_we, mem_be, mem_wdata} !== 38'd0) begin
      n_err++; $display("FAIL rst_mid_mem: got ce/we/be %b wdata %h required 0", {mem_ce, mem_we, mem_be}, mem_wdata);
    end
    n_vec++;
    if ({bus.hreadyout, bus.hresp, bus.hrdata} !== {2'b10, 32'd0}) begin
      n_err++; $display("FAIL rst_mid_bus: got rdy/resp %b hrdata %h required 10 0", {bus.hreadyout, bus.hresp}, bus.hrdata);
    end
    n_vec++;
    if (dut.wb_valid_r !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_wb_valid: got %b required 0", dut.wb_valid_r);
    end
    @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    dp_read  = 1'b0;
    dp_wdata = 32'd0;
    idle_cycle();
    n_vec++;
    if (last_ce !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_no_commit: got ce %b required 0", last_ce);
    end
    idle_cycle();
    n_vec++;
    if (sram_mem[24] !== 32'h0BADF00D) begin
      n_err++; $display("FAIL rst_mid_sram: got %h required 0badf00d", sram_mem[24]);
    end
  endtask

  initial begin
    hresetn     = 1'b0;
    bus.hsel    = 1'b0;
    bus.htrans  = HTRANS_IDLE;
    bus.hwrite  = 1'b0;
    bus.hsize   = HSIZE_WORD;
    bus.haddr   = 32'd0;
    bus.hwdata  = 32'd0;
    bus.hready  = 1'b1;
    dp_read     = 1'b0;
    dp_wdata    = 32'd0;
    last_ce     = 1'b0;
    last_we     = 1'b0;
    last_rdy    = 1'b1;
    last_resp   = 1'b0;
    last_hrdata = 32'd0;

    test_reset();
    test_write_commit();
    test_busy_idle();
    test_read_merge();
    test_byte_merge();
    test_back_to_back();
    test_misaligned();
    test_reset_mid_write();

    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++; $display("FAIL stray_read_data: got %0d unmatched reads required 0", obs_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
